load_store_unit: RTL

Sits between the core's execute stage and the word-addressed data memory; converts byte/halfword/word load and store requests into memory accesses. Word-aligned words pass directly; sub-word stores use a two-cycle read-modify-write; loads return sign- or zero-extended data. A valid/ready request channel and a valid/ready response channel let the core stall on memory operations.

---
 rtl/load_store_unit_if.sv | 33 +++
 rtl/load_store_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Request, response and data-memory bus of the load/store unit.
// The unit uses the slave modport; the core and memory side use master.
interface load_store_unit_if #(
    parameter int AW = 9
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wd;
    logic          mem_we;
    logic [31:0]   mem_rd;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_ready, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wd, mem_we
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_ready, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wd, mem_we
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-addressed memory,
// sub-word stores done as read-modify-write, loads sign/zero-extended.
module load_store_unit #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input logic              clk,
    input logic              rst_n,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

    state_t        r_state;
    state_t        w_next;
    logic          r_we;
    logic          r_unsigned;
    logic          r_err;
    logic [1:0]    r_size;
    logic [1:0]    r_lane;
    logic [AW-1:0] r_waddr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic [31:0]   r_word;

    logic          w_err;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;
    logic [31:0]   w_merged;

    assign w_err = (bus.req_size == 2'd3)
                || (bus.req_size == 2'd1 && bus.req_addr[0])
                || (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00)
                || (bus.req_addr >= ADDR_LIMIT);

    // Little-endian lane selection and extension of the memory read word.
    always_comb begin
        w_byte = bus.mem_rd[7:0];
        case (r_lane)
            2'd1:    w_byte = bus.mem_rd[15:8];
            2'd2:    w_byte = bus.mem_rd[23:16];
            2'd3:    w_byte = bus.mem_rd[31:24];
            default: w_byte = bus.mem_rd[7:0];
        endcase
        w_half = r_lane[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
        case (r_size)
            2'd0:    w_load = {{24{!r_unsigned && w_byte[7]}}, w_byte};
            2'd1:    w_load = {{16{!r_unsigned && w_half[15]}}, w_half};
            default: w_load = bus.mem_rd;
        endcase
    end

    always_comb begin
        w_merged = r_word;
        if (r_size == 2'd0) begin
            case (r_lane)
                2'd1:    w_merged[15:8]  = r_wdata[7:0];
                2'd2:    w_merged[23:16] = r_wdata[7:0];
                2'd3:    w_merged[31:24] = r_wdata[7:0];
                default: w_merged[7:0]   = r_wdata[7:0];
            endcase
        end else if (r_lane[1]) begin
            w_merged[31:16] = r_wdata[15:0];
        end else begin
            w_merged[15:0] = r_wdata[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_size     <= 2'd0;
            r_lane     <= 2'd0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_word     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_we       <= bus.req_we;
                        r_unsigned <= bus.req_unsigned;
                        r_err      <= w_err;
                        r_size     <= bus.req_size;
                        r_lane     <= bus.req_addr[1:0];
                        r_waddr    <= bus.req_addr[AW+1:2];
                        r_wdata    <= bus.req_wdata;
                        r_rdata    <= '0;
                    end
                end
                ACCESS: begin
                    if (!r_we) begin
                        r_rdata <= w_load;
                    end
                    r_word <= bus.mem_rd;
                end
                default: begin
                end
            endcase
        end
    end

    // Memory strobes depend only on state and latched request, never on live inputs.
    always_comb begin
        w_next        = r_state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;
        bus.mem_addr  = r_waddr;
        bus.mem_we    = 1'b0;
        bus.mem_wd    = '0;
        case (r_state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_next = w_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (r_we && r_size == 2'd2) begin
                    bus.mem_we = 1'b1;
                    bus.mem_wd = r_wdata;
                end
                w_next = (r_we && r_size != 2'd2) ? MERGE : RESP;
            end
            MERGE: begin
                bus.mem_we = 1'b1;
                bus.mem_wd = w_merged;
                w_next     = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_rdata = r_rdata;
                bus.rsp_err   = r_err;
                if (bus.rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end
endmodule
